// File: rtl/conv_weight_scheduler.sv
// Weight-load sequencer for a bank of parallel 3x3 binary conv engines.
// For each kernel group of a layer it streams CONV_N*K one-bit weights out
// of the weight ROM (K bits per engine, engines in order), launches every
// engine together, then waits until each engine has reported completion.
// The layer ends with a one-cycle done pulse.
module conv_weight_scheduler #(
  parameter int CONV_N = 3,
  parameter int K      = 9,
  parameter int AW     = 10,
  parameter int GW     = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [AW-1:0]     base_addr,
  input  logic [GW-1:0]     n_groups,
  output logic              wrom_rd,
  output logic [AW-1:0]     wrom_addr,
  input  logic              wrom_data,
  output logic              conv_weight,
  output logic [CONV_N-1:0] weight_en,
  output logic [CONV_N-1:0] conv_start,
  input  logic [CONV_N-1:0] conv_done,
  output logic [GW-1:0]     group_idx,
  output logic              busy,
  output logic              done
);

  localparam int BW = (K > 1) ? $clog2(K) : 1;
  localparam int EW = (CONV_N > 1) ? $clog2(CONV_N) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(K - 1);
  localparam logic [EW-1:0] ENG_LAST = EW'(CONV_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_LAUNCH,
    S_WAIT,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]     addr_ptr;
  logic [BW-1:0]     bit_cnt;
  logic [EW-1:0]     eng_cnt;
  logic [GW-1:0]     n_groups_q;
  logic [CONV_N-1:0] done_seen;
  logic [CONV_N-1:0] en_q;
  logic              accept;
  logic              last_read;
  logic              all_done;
  logic              last_group;

  assign last_read  = (bit_cnt == BIT_LAST) && (eng_cnt == ENG_LAST);
  assign all_done   = &(done_seen | conv_done);
  assign last_group = (group_idx == n_groups_q - GW'(1));

  // ROM data goes straight to the engines; weight_en qualifies it.
  assign conv_weight = wrom_data;
  assign wrom_addr   = wrom_rd ? addr_ptr : '0;
  // The enable registered from last cycle's read is squashed by an abort.
  assign weight_en   = abort ? '0 : en_q;
  // Busy covers the accepting cycle itself and every non-idle cycle.
  assign busy        = (state != S_IDLE) || accept;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-state strobes; abort overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    accept     = 1'b0;
    wrom_rd    = 1'b0;
    conv_start = '0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (n_groups == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        wrom_rd = 1'b1;
        if (last_read) state_nxt = S_DRAIN;
      end
      S_DRAIN:  state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        conv_start = '1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (all_done) state_nxt = last_group ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt  = S_IDLE;
      accept     = 1'b0;
      wrom_rd    = 1'b0;
      conv_start = '0;
      done       = 1'b0;
    end
  end

  // Address pointer, bit/engine counters, group index and completion tracking.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here samples the pre-edge values of the others, independent of order.
    if (!rstn) begin
      addr_ptr   <= '0;
      bit_cnt    <= '0;
      eng_cnt    <= '0;
      n_groups_q <= '0;
      group_idx  <= '0;
      done_seen  <= '0;
      en_q       <= '0;
    end else if (abort) begin
      bit_cnt   <= '0;
      eng_cnt   <= '0;
      group_idx <= '0;
      done_seen <= '0;
      en_q      <= '0;
    end else begin
      en_q <= wrom_rd ? (CONV_N'(1) << eng_cnt) : '0;
      if (accept) begin
        n_groups_q <= n_groups;
        addr_ptr   <= base_addr;
        group_idx  <= '0;
        bit_cnt    <= '0;
        eng_cnt    <= '0;
      end
      if (wrom_rd) begin
        // Pointer wraps naturally at the top of the ROM.
        addr_ptr <= addr_ptr + AW'(1);
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          eng_cnt <= (eng_cnt == ENG_LAST) ? '0 : eng_cnt + EW'(1);
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
      if (state == S_LAUNCH) done_seen <= '0;
      if (state == S_WAIT) begin
        done_seen <= done_seen | conv_done;
        if (all_done && !last_group) group_idx <= group_idx + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_weight_scheduler.sv
// Self-checking bench for conv_weight_scheduler. A layer-level model follows
// each run as a sequence of reads, drain, launch, wait and finish, and a
// compare process checks every output on every falling edge; directed cases
// add literal checks on latency, read counts, wrap-around and abort/reset.
module tb_conv_weight_scheduler;

  localparam int CONV_N = 3;
  localparam int K      = 9;
  localparam int AW     = 10;
  localparam int GW     = 6;
  localparam int NR     = CONV_N * K;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [GW-1:0]     n_groups = '0;
  logic              wrom_rd;
  logic [AW-1:0]     wrom_addr;
  logic              wrom_data = 1'b0;
  logic              conv_weight;
  logic [CONV_N-1:0] weight_en;
  logic [CONV_N-1:0] conv_start;
  logic [CONV_N-1:0] conv_done = '0;
  logic [GW-1:0]     group_idx;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  conv_weight_scheduler #(.CONV_N(CONV_N), .K(K), .AW(AW), .GW(GW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_addr(base_addr), .n_groups(n_groups),
    .wrom_rd(wrom_rd), .wrom_addr(wrom_addr), .wrom_data(wrom_data),
    .conv_weight(conv_weight), .weight_en(weight_en), .conv_start(conv_start),
    .conv_done(conv_done), .group_idx(group_idx), .busy(busy), .done(done)
  );

  // Weight ROM: data appears the cycle after the read strobe.
  logic rom [0:(1<<AW)-1];
  always @(posedge clk) wrom_data <= wrom_rd ? rom[wrom_addr] : 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- layer-level model ----------------
  logic              e_rd, e_w, e_busy, e_done;
  logic [AW-1:0]     e_addr;
  logic [CONV_N-1:0] e_en, e_cs;
  logic [GW-1:0]     e_group;
  logic [GW-1:0]     m_group = '0;

  task automatic clr_exp();
    e_rd = 1'b0; e_w = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    e_addr = '0; e_en = '0; e_cs = '0; e_group = m_group;
  endtask

  // Advance one cycle; report whether reset or abort ends the current run.
  task automatic mtick(input bit in_layer, output bit killed);
    @(posedge clk); #2;
    clr_exp();
    killed = 1'b0;
    if (!rstn) begin
      killed = 1'b1; m_group = '0; e_group = '0;
    end else if (abort) begin
      killed = 1'b1; e_busy = in_layer; m_group = '0;
    end
  endtask

  task automatic run_layer(input logic [AW-1:0] b, input logic [GW-1:0] ng);
    bit                k;
    logic [AW-1:0]     ptr;
    logic [CONV_N-1:0] prev_en, ds;
    logic              prev_bit;
    ptr = b; prev_bit = 1'b0; m_group = '0;
    for (int g = 0; g < int'(ng); g++) begin
      prev_en = '0;
      for (int i = 0; i < NR; i++) begin
        mtick(1'b1, k); if (k) return;
        e_busy = 1'b1; e_rd = 1'b1; e_addr = ptr; e_en = prev_en; e_w = prev_bit;
        prev_en = CONV_N'(1) << (i / K);
        prev_bit = rom[ptr];
        ptr = ptr + 1'b1;
      end
      mtick(1'b1, k); if (k) return;
      e_busy = 1'b1; e_en = prev_en; e_w = prev_bit;
      mtick(1'b1, k); if (k) return;
      e_busy = 1'b1; e_cs = '1;
      ds = '0;
      do begin
        mtick(1'b1, k); if (k) return;
        e_busy = 1'b1;
        ds = ds | conv_done;
      end while (ds != '1);
      if (g != int'(ng) - 1) m_group = GW'(g + 1);
    end
    mtick(1'b1, k); if (k) return;
    e_busy = 1'b1; e_done = 1'b1;
  endtask

  initial begin
    bit k;
    clr_exp();
    forever begin
      mtick(1'b0, k);
      if (!k && start) begin
        e_busy = 1'b1;
        run_layer(base_addr, n_groups);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("wrom_rd", 32'(wrom_rd), 32'(e_rd));
    if (e_rd) check("wrom_addr", 32'(wrom_addr), 32'(e_addr));
    check("weight_en", 32'(weight_en), 32'(e_en));
    if (e_en != '0) check("conv_weight", 32'(conv_weight), 32'(e_w));
    check("conv_start", 32'(conv_start), 32'(e_cs));
    check("group_idx", 32'(group_idx), 32'(e_group));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
  end

  // ---------------- event monitor ----------------
  int            rd_cnt, cs_cnt, done_cnt, busy_cnt, first_cs_cyc, done_cyc, wrap_seen;
  logic [AW-1:0] first_rd_addr, last_rd_addr, prev_addr;
  logic          prev_rd = 1'b0;

  always @(negedge clk) begin
    if (wrom_rd) begin
      if (rd_cnt == 0) first_rd_addr = wrom_addr;
      last_rd_addr = wrom_addr;
      rd_cnt++;
      if (prev_rd && prev_addr == '1 && wrom_addr == '0) wrap_seen = 1;
    end
    prev_rd = wrom_rd; prev_addr = wrom_addr;
    if (conv_start != '0) begin
      if (cs_cnt == 0) first_cs_cyc = cyc;
      cs_cnt++;
    end
    if (done) begin done_cyc = cyc; done_cnt++; end
    if (busy) busy_cnt++;
  end

  task automatic clear_mon();
    rd_cnt = 0; cs_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_cs_cyc = 0; done_cyc = 0; wrap_seen = 0;
    first_rd_addr = '0; last_rd_addr = '0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [GW-1:0] ng);
    base_addr = b; n_groups = ng; start = 1'b1; start_cyc = cyc;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_cs(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (conv_start != '0) begin found = 1'b1; break; end
      cycle();
    end
    if (!found) check("conv_start_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin found = 1'b1; break; end
      cycle();
    end
    if (!found) check("done_timeout", 32'(found), 32'd1);
  endtask

  task automatic finish_group();
    wait_cs(80);
    cycle(); conv_done = '1;
    cycle(); conv_done = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rd"}, 32'(wrom_rd), 32'd0);
    check({tag, "_en"}, 32'(weight_en), 32'd0);
    check({tag, "_cs"}, 32'(conv_start), 32'd0);
    check({tag, "_group"}, 32'(group_idx), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int l_cyc;
    for (int i = 0; i < (1 << AW); i++) rom[i] = 1'(((i * 37 + 5) >> 3) ^ (i >> 1));
    clear_mon();

    rstn = 1'b0;
    repeat (3) cycle();
    check_idle_outputs("reset");
    rstn = 1'b1;
    cycle();

    // 1: single group, latency and read window
    clear_mon();
    do_start(10'h010, 6'd1);
    wait_cs(80);
    check("t1_latency", 32'(cyc - start_cyc), 32'd29);
    cycle(); conv_done = '1;
    cycle(); conv_done = '0;
    wait_done(40);
    repeat (2) cycle();
    check("t1_reads", 32'(rd_cnt), 32'd27);
    check("t1_first_addr", 32'(first_rd_addr), 32'h010);
    check("t1_last_addr", 32'(last_rd_addr), 32'h02A);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: two groups, staggered completion
    clear_mon();
    do_start(10'h100, 6'd2);
    wait_cs(80);
    l_cyc = cyc;
    for (int d = 1; d <= 12; d++) begin
      cycle();
      conv_done = (d == 5) ? 3'b001 : (d == 8) ? 3'b100 : (d == 12) ? 3'b010 : 3'b000;
    end
    cycle(); conv_done = '0;
    check("t2_reload_cyc", 32'(cyc - l_cyc), 32'd13);
    check("t2_reload_rd", 32'(wrom_rd), 32'd1);
    check("t2_reload_addr", 32'(wrom_addr), 32'h11B);
    check("t2_group", 32'(group_idx), 32'd1);
    check("t2_no_early_done", 32'(done_cnt), 32'd0);
    finish_group();
    wait_done(40);
    repeat (3) cycle();
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_reads", 32'(rd_cnt), 32'd54);
    check("t2_cs_cnt", 32'(cs_cnt), 32'd2);

    // 3: address wrap across the top of the ROM
    clear_mon();
    do_start(10'h3F0, 6'd2);
    finish_group();
    finish_group();
    wait_done(40);
    cycle();
    check("t3_reads", 32'(rd_cnt), 32'd54);
    check("t3_wrap", 32'(wrap_seen), 32'd1);
    check("t3_last_addr", 32'(last_rd_addr), 32'h025);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);

    // 4: empty layer; start also held into the finish cycle
    clear_mon();
    base_addr = 10'h055; n_groups = 6'd0; start = 1'b1; start_cyc = cyc;
    cycle();
    cycle(); start = 1'b0;
    repeat (3) cycle();
    check("t4_reads", 32'(rd_cnt), 32'd0);
    check("t4_cs_cnt", 32'(cs_cnt), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    check("t4_done_lat", 32'(done_cyc - start_cyc), 32'd1);
    check("t4_busy_cycles", 32'(busy_cnt), 32'd2);

    // 5: abort in LOAD at read 13, abort in WAIT, then a clean run
    clear_mon();
    do_start(10'h080, 6'd1);
    repeat (12) cycle();
    abort = 1'b1;
    cycle(); abort = 1'b0;
    check_idle_outputs("t5_load_abort");
    repeat (3) cycle();
    check("t5_reads", 32'(rd_cnt), 32'd12);
    check("t5_done_cnt", 32'(done_cnt), 32'd0);
    clear_mon();
    do_start(10'h0C0, 6'd2);
    wait_cs(80);
    repeat (2) cycle();
    abort = 1'b1;
    cycle(); abort = 1'b0;
    check_idle_outputs("t5_wait_abort");
    repeat (2) cycle();
    check("t5_wait_done_cnt", 32'(done_cnt), 32'd0);
    clear_mon();
    do_start(10'h200, 6'd1);
    finish_group();
    wait_done(40);
    cycle();
    check("t5_restart_addr", 32'(first_rd_addr), 32'h200);
    check("t5_restart_reads", 32'(rd_cnt), 32'd27);
    check("t5_restart_done", 32'(done_cnt), 32'd1);

    // 6: stray conv_done in LOAD, start while busy, reset mid-WAIT
    clear_mon();
    conv_done = '1;
    do_start(10'h040, 6'd1);
    repeat (5) cycle();
    base_addr = 10'h300; n_groups = 6'd5; start = 1'b1;
    cycle(); start = 1'b0;
    wait_cs(80);
    conv_done = '0;
    repeat (3) cycle();
    rstn = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    repeat (2) cycle();
    rstn = 1'b1;
    repeat (3) cycle();
    check("t6_reads", 32'(rd_cnt), 32'd27);
    check("t6_first_addr", 32'(first_rd_addr), 32'h040);
    check("t6_cs_cnt", 32'(cs_cnt), 32'd1);
    check("t6_done_cnt", 32'(done_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
